df_channel_profiler: RTL and testbench
======================================

# df_channel_profiler

Parametrised dataflow channel profiler for the co-simulation monitor layer. It tracks NUM_CH FIFO channels at once and keeps, per channel, occupancy, high-water mark, read-stall cycles, write-stall cycles and transfer count. A global stall watchdog declares a deadlock after STALL_TIMEOUT consecutive blocked cycles with no transfer, and the profiler then freezes all statistics. Results are read back through a registered select port, so the block can replace per-channel monitor instances and still work with the existing CSV dump flow.

## Interface
Parameters:
- NUM_CH, 6, number of monitored channels (1..32)
- DEPTH_W, 16, occupancy / high-water counter width
- CNT_W, 32, stall and transfer counter width
- STALL_TIMEOUT, 1024, quiet-and-blocked cycles that trigger deadlock (>=2, fits CNT_W)

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  start profiling (IDLE->RUN)
- clear  in  1  synchronous clear: counters to 0, state to IDLE
- finish  in  1  design completed; freeze statistics
- wr_en  in  NUM_CH  per-channel write strobe
- rd_en  in  NUM_CH  per-channel read strobe
- wr_block  in  NUM_CH  producer blocked on channel (~blk_n)
- rd_block  in  NUM_CH  consumer blocked on channel (~blk_n)
- sel  in  max(1,$clog2(NUM_CH))  readout channel select
- depth_o  out  DEPTH_W  current occupancy of channel sel
- max_depth_o  out  DEPTH_W  high-water mark of channel sel
- rd_stall_o  out  CNT_W  read-blocked cycles of channel sel
- wr_stall_o  out  CNT_W  write-blocked cycles of channel sel
- xfer_o  out  CNT_W  write count of channel sel
- underflow  out  NUM_CH  sticky per-channel read-while-empty flag
- state_o  out  2  00 IDLE, 01 RUN, 10 DONE, 11 DEADLOCK
- deadlock  out  1  sticky; high in DEADLOCK
- deadlock_mask  out  NUM_CH  channels with rd_block|wr_block at detection

## Operation
- States:
  - IDLE: inputs are ignored. Moves to RUN when enable=1.
  - RUN: all statistics update. Moves to DONE on finish=1, or to DEADLOCK on watchdog expiry.
  - DONE and DEADLOCK: all statistics are frozen. The only exit is clear or reset.
- Priority per edge: clear > finish > watchdog expiry > enable.
- Occupancy update (RUN only), per channel:
  - wr only: +1.
  - rd only: -1.
  - both or neither: unchanged.
  - rd only at depth 0: depth stays 0 and underflow[ch] is set.
  - wr only at all-ones: depth holds.
- High-water mark: max_depth <= max(max_depth, next depth).
- rd_stall and wr_stall: +1 per RUN cycle with rd_block[ch] or wr_block[ch] respectively.
- xfer: +1 per RUN cycle with wr_en[ch].
- All CNT_W counters saturate at all-ones and never wrap.
- Watchdog:
  - A cycle is "quiet" when |wr_en==0, |rd_en==0 and |(rd_block|wr_block)==1.
  - In RUN, the quiet counter increments on a quiet cycle and returns to 0 on any other cycle.
  - The watchdog expires when the counter would reach STALL_TIMEOUT.
  - On expiry, deadlock_mask captures rd_block|wr_block from the same edge.
- clear zeroes every counter, underflow, deadlock and deadlock_mask.

## Timing
- Reset values: every output is 0, state_o=IDLE.
- Readout latency is 1 cycle. The *_o outputs are registered copies of channel sel as of the previous edge, including updates made on that edge.
- Timeout timing: with quiet cycles sampled on edges k..k+STALL_TIMEOUT-1, deadlock=1 and state_o=11 after edge k+STALL_TIMEOUT-1.
- A single non-quiet cycle anywhere in that window restarts the count.
- finish and watchdog expiry on the same edge: DONE, and deadlock stays 0.
- enable and clear on the same edge: state is IDLE.
- sel >= NUM_CH reads all zeros.
- Reset asserted mid-run clears everything immediately (asynchronous). Release is synchronous to clock.

## Test plan
- Reset then enable. Channel 0 gets 5 writes, then 3 reads, then 1 simultaneous rd+wr. Expected at sel=0: depth_o=2, max_depth_o=5, xfer_o=6.
- Read channel 2 while empty: underflow[2]=1 and depth stays 0. Then pulse clear: underflow=0, state_o=IDLE.
- STALL_TIMEOUT=16, rd_block[1]=1, no strobes:
  - deadlock=1 after the 16th quiet edge, deadlock_mask=000010.
  - A wr_en at the 10th edge delays detection by 10 cycles.
- finish together with watchdog expiry: state_o=DONE, deadlock=0. Further wr_en/rd_en leave all readouts unchanged.
- CNT_W=4, wr_block[3] held for 20 RUN cycles: wr_stall_o at sel=3 is 15 (saturated).
- Drop reset during RUN with counters non-zero: all outputs are 0 in the same cycle and state_o=IDLE.

Source files
------------

// File: rtl/df_channel_profiler.sv
// Multi-channel FIFO profiler: per-channel occupancy, high-water, stall and transfer
// statistics with a global stall watchdog and a registered per-channel readout port.
module df_channel_profiler #(
  parameter int NUM_CH        = 6,
  parameter int DEPTH_W       = 16,
  parameter int CNT_W         = 32,
  parameter int STALL_TIMEOUT = 1024,
  localparam int SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic               finish,
  input  logic [NUM_CH-1:0]  wr_en,
  input  logic [NUM_CH-1:0]  rd_en,
  input  logic [NUM_CH-1:0]  wr_block,
  input  logic [NUM_CH-1:0]  rd_block,
  input  logic [SEL_W-1:0]   sel,
  output logic [DEPTH_W-1:0] depth_o,
  output logic [DEPTH_W-1:0] max_depth_o,
  output logic [CNT_W-1:0]   rd_stall_o,
  output logic [CNT_W-1:0]   wr_stall_o,
  output logic [CNT_W-1:0]   xfer_o,
  output logic [NUM_CH-1:0]  underflow,
  output logic [1:0]         state_o,
  output logic               deadlock,
  output logic [NUM_CH-1:0]  deadlock_mask
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_RUN      = 2'b01,
    S_DONE     = 2'b10,
    S_DEADLOCK = 2'b11
  } state_t;

  state_t r_state, w_state_nxt;

  logic [DEPTH_W-1:0] r_depth    [NUM_CH];
  logic [DEPTH_W-1:0] r_max      [NUM_CH];
  logic [CNT_W-1:0]   r_rd_stall [NUM_CH];
  logic [CNT_W-1:0]   r_wr_stall [NUM_CH];
  logic [CNT_W-1:0]   r_xfer     [NUM_CH];
  logic [NUM_CH-1:0]  r_underflow;
  logic [CNT_W-1:0]   r_quiet;
  logic               r_deadlock;
  logic [NUM_CH-1:0]  r_mask;

  logic [DEPTH_W-1:0] w_depth_nxt    [NUM_CH];
  logic [DEPTH_W-1:0] w_max_nxt      [NUM_CH];
  logic [CNT_W-1:0]   w_rd_stall_nxt [NUM_CH];
  logic [CNT_W-1:0]   w_wr_stall_nxt [NUM_CH];
  logic [CNT_W-1:0]   w_xfer_nxt     [NUM_CH];
  logic [NUM_CH-1:0]  w_underflow_nxt;
  logic [CNT_W-1:0]   w_quiet_nxt;
  logic               w_deadlock_nxt;
  logic [NUM_CH-1:0]  w_mask_nxt;

  logic               w_run;
  logic               w_quiet;
  logic               w_expire;

  logic [DEPTH_W-1:0] r_depth_o, r_max_o, w_sel_depth, w_sel_max;
  logic [CNT_W-1:0]   r_rd_stall_o, r_wr_stall_o, r_xfer_o;
  logic [CNT_W-1:0]   w_sel_rd_stall, w_sel_wr_stall, w_sel_xfer;

  assign w_run    = (r_state == S_RUN);
  assign w_quiet  = ~(|wr_en) & ~(|rd_en) & (|(rd_block | wr_block));
  // Expiry fires on the edge where the quiet count would reach the timeout.
  assign w_expire = w_run && w_quiet && (r_quiet == CNT_W'(STALL_TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (enable) w_state_nxt = S_RUN;
        S_RUN: begin
          if (finish)        w_state_nxt = S_DONE;
          else if (w_expire) w_state_nxt = S_DEADLOCK;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_underflow_nxt = r_underflow;
    w_quiet_nxt     = r_quiet;
    w_deadlock_nxt  = r_deadlock;
    w_mask_nxt      = r_mask;
    for (int i = 0; i < NUM_CH; i++) begin
      w_depth_nxt[i]    = r_depth[i];
      w_max_nxt[i]      = r_max[i];
      w_rd_stall_nxt[i] = r_rd_stall[i];
      w_wr_stall_nxt[i] = r_wr_stall[i];
      w_xfer_nxt[i]     = r_xfer[i];
    end
    if (clear) begin
      w_underflow_nxt = '0;
      w_quiet_nxt     = '0;
      w_deadlock_nxt  = 1'b0;
      w_mask_nxt      = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        w_depth_nxt[i]    = '0;
        w_max_nxt[i]      = '0;
        w_rd_stall_nxt[i] = '0;
        w_wr_stall_nxt[i] = '0;
        w_xfer_nxt[i]     = '0;
      end
    end else if (w_run) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_en[i] && !rd_en[i] && (r_depth[i] != '1)) begin
          w_depth_nxt[i] = r_depth[i] + 1'b1;
        end else if (rd_en[i] && !wr_en[i]) begin
          if (r_depth[i] == '0) w_underflow_nxt[i] = 1'b1;
          else                  w_depth_nxt[i]     = r_depth[i] - 1'b1;
        end
        if (w_depth_nxt[i] > r_max[i]) w_max_nxt[i] = w_depth_nxt[i];
        if (rd_block[i] && (r_rd_stall[i] != '1)) w_rd_stall_nxt[i] = r_rd_stall[i] + 1'b1;
        if (wr_block[i] && (r_wr_stall[i] != '1)) w_wr_stall_nxt[i] = r_wr_stall[i] + 1'b1;
        if (wr_en[i] && (r_xfer[i] != '1))        w_xfer_nxt[i]     = r_xfer[i] + 1'b1;
      end
      w_quiet_nxt = w_quiet ? (r_quiet + 1'b1) : '0;
      // finish outranks expiry: no deadlock is recorded when both land together.
      if (w_expire && !finish) begin
        w_deadlock_nxt = 1'b1;
        w_mask_nxt     = rd_block | wr_block;
      end
    end
  end

  always_comb begin
    w_sel_depth    = '0;
    w_sel_max      = '0;
    w_sel_rd_stall = '0;
    w_sel_wr_stall = '0;
    w_sel_xfer     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) begin
        w_sel_depth    = w_depth_nxt[i];
        w_sel_max      = w_max_nxt[i];
        w_sel_rd_stall = w_rd_stall_nxt[i];
        w_sel_wr_stall = w_wr_stall_nxt[i];
        w_sel_xfer     = w_xfer_nxt[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_underflow  <= '0;
      r_quiet      <= '0;
      r_deadlock   <= 1'b0;
      r_mask       <= '0;
      r_depth_o    <= '0;
      r_max_o      <= '0;
      r_rd_stall_o <= '0;
      r_wr_stall_o <= '0;
      r_xfer_o     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_depth[i]    <= '0;
        r_max[i]      <= '0;
        r_rd_stall[i] <= '0;
        r_wr_stall[i] <= '0;
        r_xfer[i]     <= '0;
      end
    end else begin
      r_state      <= w_state_nxt;
      r_underflow  <= w_underflow_nxt;
      r_quiet      <= w_quiet_nxt;
      r_deadlock   <= w_deadlock_nxt;
      r_mask       <= w_mask_nxt;
      r_depth_o    <= w_sel_depth;
      r_max_o      <= w_sel_max;
      r_rd_stall_o <= w_sel_rd_stall;
      r_wr_stall_o <= w_sel_wr_stall;
      r_xfer_o     <= w_sel_xfer;
      for (int i = 0; i < NUM_CH; i++) begin
        r_depth[i]    <= w_depth_nxt[i];
        r_max[i]      <= w_max_nxt[i];
        r_rd_stall[i] <= w_rd_stall_nxt[i];
        r_wr_stall[i] <= w_wr_stall_nxt[i];
        r_xfer[i]     <= w_xfer_nxt[i];
      end
    end
  end

  assign depth_o       = r_depth_o;
  assign max_depth_o   = r_max_o;
  assign rd_stall_o    = r_rd_stall_o;
  assign wr_stall_o    = r_wr_stall_o;
  assign xfer_o        = r_xfer_o;
  assign underflow     = r_underflow;
  assign state_o       = r_state;
  assign deadlock      = r_deadlock;
  assign deadlock_mask = r_mask;

endmodule

// File: tb/tb_df_channel_profiler.sv
// Bench for df_channel_profiler: directed scenarios plus random traffic, checked
// cycle by cycle against an arithmetic reference model through an expected queue.
module tb_df_channel_profiler;

  localparam int NUM_CH  = 6;
  localparam int DEPTH_W = 4;
  localparam int CNT_W   = 5;
  localparam int T       = 16;
  localparam int SEL_W   = 3;
  localparam int DMAX    = (1 << DEPTH_W) - 1;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable, clear, finish;
  logic [NUM_CH-1:0]  wr_en, rd_en, wr_block, rd_block;
  logic [SEL_W-1:0]   sel;
  logic [DEPTH_W-1:0] depth_o, max_depth_o;
  logic [CNT_W-1:0]   rd_stall_o, wr_stall_o, xfer_o;
  logic [NUM_CH-1:0]  underflow, deadlock_mask;
  logic [1:0]         state_o;
  logic               deadlock;

  df_channel_profiler #(
    .NUM_CH(NUM_CH), .DEPTH_W(DEPTH_W), .CNT_W(CNT_W), .STALL_TIMEOUT(T)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .finish(finish),
    .wr_en(wr_en), .rd_en(rd_en), .wr_block(wr_block), .rd_block(rd_block), .sel(sel),
    .depth_o(depth_o), .max_depth_o(max_depth_o), .rd_stall_o(rd_stall_o),
    .wr_stall_o(wr_stall_o), .xfer_o(xfer_o), .underflow(underflow),
    .state_o(state_o), .deadlock(deadlock), .deadlock_mask(deadlock_mask)
  );

  // clock / reset
  always #5 clock = ~clock;

  // scoreboard
  typedef struct packed {
    logic [DEPTH_W-1:0] depth;
    logic [DEPTH_W-1:0] maxd;
    logic [CNT_W-1:0]   rds;
    logic [CNT_W-1:0]   wrs;
    logic [CNT_W-1:0]   xfer;
    logic [NUM_CH-1:0]  uf;
    logic [1:0]         st;
    logic               dl;
    logic [NUM_CH-1:0]  mask;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // reference model: plain integers, one call per clock edge
  int          m_depth[NUM_CH], m_max[NUM_CH], m_rds[NUM_CH], m_wrs[NUM_CH], m_xfer[NUM_CH];
  bit [NUM_CH-1:0] m_uf, m_mask;
  int          m_state, m_quiet;
  bit          m_dl;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_depth[c] = 0; m_max[c] = 0; m_rds[c] = 0; m_wrs[c] = 0; m_xfer[c] = 0;
    end
    m_uf = '0; m_mask = '0; m_state = 0; m_quiet = 0; m_dl = 1'b0;
  endfunction

  function automatic void model_edge();
    bit quiet;
    if (clear) begin
      model_reset();
    end else if (m_state == 0) begin
      if (enable) m_state = 1;
    end else if (m_state == 1) begin
      quiet = (wr_en == 0) && (rd_en == 0) && ((rd_block | wr_block) != 0);
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_en[c] && !rd_en[c]) m_depth[c] = imin(m_depth[c] + 1, DMAX);
        else if (rd_en[c] && !wr_en[c]) begin
          if (m_depth[c] == 0) m_uf[c] = 1'b1;
          else m_depth[c] = m_depth[c] - 1;
        end
        if (m_depth[c] > m_max[c]) m_max[c] = m_depth[c];
        if (rd_block[c]) m_rds[c]  = imin(m_rds[c] + 1, CMAX);
        if (wr_block[c]) m_wrs[c]  = imin(m_wrs[c] + 1, CMAX);
        if (wr_en[c])    m_xfer[c] = imin(m_xfer[c] + 1, CMAX);
      end
      m_quiet = quiet ? m_quiet + 1 : 0;
      if (finish) m_state = 2;
      else if (m_quiet == T) begin
        m_state = 3; m_dl = 1'b1; m_mask = rd_block | wr_block;
      end
    end
  endfunction

  function automatic exp_t model_readout();
    exp_t e;
    e = '0;
    if (int'(sel) < NUM_CH) begin
      e.depth = DEPTH_W'(m_depth[sel]);
      e.maxd  = DEPTH_W'(m_max[sel]);
      e.rds   = CNT_W'(m_rds[sel]);
      e.wrs   = CNT_W'(m_wrs[sel]);
      e.xfer  = CNT_W'(m_xfer[sel]);
    end
    e.uf = m_uf; e.st = 2'(m_state); e.dl = m_dl; e.mask = m_mask;
    return e;
  endfunction

  // monitor: one expected entry per clock edge with reset released
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (reset && exp_q.size() > 0) begin
      e = exp_t'(exp_q.pop_front());
      chk("depth_o",       depth_o,       e.depth);
      chk("max_depth_o",   max_depth_o,   e.maxd);
      chk("rd_stall_o",    rd_stall_o,    e.rds);
      chk("wr_stall_o",    wr_stall_o,    e.wrs);
      chk("xfer_o",        xfer_o,        e.xfer);
      chk("underflow",     underflow,     e.uf);
      chk("state_o",       state_o,       e.st);
      chk("deadlock",      deadlock,      e.dl);
      chk("deadlock_mask", deadlock_mask, e.mask);
    end
  end

  // driver tasks
  task automatic step(input logic [NUM_CH-1:0] we, input logic [NUM_CH-1:0] re,
                      input logic [NUM_CH-1:0] wb, input logic [NUM_CH-1:0] rb,
                      input logic en, input logic clr, input logic fin,
                      input logic [SEL_W-1:0] s);
    @(negedge clock);
    wr_en = we; rd_en = re; wr_block = wb; rd_block = rb;
    enable = en; clear = clr; finish = fin; sel = s;
    model_edge();
    exp_q.push_back(EXP_W'(model_readout()));
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_step(input logic en, input logic clr, input logic fin, input logic [SEL_W-1:0] s);
    step('0, '0, '0, '0, en, clr, fin, s);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_depth"},    depth_o,       0);
    chk({tag, "_max"},      max_depth_o,   0);
    chk({tag, "_rdstall"},  rd_stall_o,    0);
    chk({tag, "_wrstall"},  wr_stall_o,    0);
    chk({tag, "_xfer"},     xfer_o,        0);
    chk({tag, "_uf"},       underflow,     0);
    chk({tag, "_state"},    state_o,       0);
    chk({tag, "_deadlock"}, deadlock,      0);
    chk({tag, "_mask"},     deadlock_mask, 0);
  endtask

  initial begin
    logic [NUM_CH-1:0] we, re, wb, rb;
    reset = 1'b0; enable = 0; clear = 0; finish = 0;
    wr_en = '0; rd_en = '0; wr_block = '0; rd_block = '0; sel = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #2;
    chk_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;

    // occupancy / high-water / transfer count on channel 0
    idle_step(1, 0, 0, 0);
    repeat (5) step(6'b000001, '0, '0, '0, 0, 0, 0, 0);
    repeat (3) step('0, 6'b000001, '0, '0, 0, 0, 0, 0);
    step(6'b000001, 6'b000001, '0, '0, 0, 0, 0, 0);
    settle();
    chk("t1_depth", depth_o, 2);
    chk("t1_max", max_depth_o, 5);
    chk("t1_xfer", xfer_o, 6);

    // underflow on empty channel 2, then clear
    step('0, 6'b000100, '0, '0, 0, 0, 0, 2);
    settle();
    chk("t2_underflow", underflow[2], 1);
    chk("t2_depth", depth_o, 0);
    idle_step(0, 1, 0, 2);
    settle();
    chk("t2_clr_uf", underflow, 0);
    chk("t2_clr_state", state_o, 0);

    // watchdog: 16 quiet edges with rd_block[1]
    idle_step(1, 0, 0, 1);
    repeat (T - 1) step('0, '0, '0, 6'b000010, 0, 0, 0, 1);
    settle();
    chk("t3_pre_state", state_o, 1);
    step('0, '0, '0, 6'b000010, 0, 0, 0, 1);
    settle();
    chk("t3_state", state_o, 3);
    chk("t3_deadlock", deadlock, 1);
    chk("t3_mask", deadlock_mask, 6'b000010);

    // a write on the 10th edge restarts the count
    idle_step(0, 1, 0, 1);
    idle_step(1, 0, 0, 1);
    repeat (9) step('0, '0, '0, 6'b000010, 0, 0, 0, 1);
    step(6'b000001, '0, '0, 6'b000010, 0, 0, 0, 1);
    repeat (T - 1) step('0, '0, '0, 6'b000010, 0, 0, 0, 1);
    settle();
    chk("t4_pre_state", state_o, 1);
    step('0, '0, '0, 6'b000010, 0, 0, 0, 1);
    settle();
    chk("t4_state", state_o, 3);

    // finish coincides with expiry
    idle_step(0, 1, 0, 1);
    idle_step(1, 0, 0, 1);
    repeat (T - 1) step('0, '0, '0, 6'b000010, 0, 0, 0, 1);
    step('0, '0, '0, 6'b000010, 0, 0, 1, 1);
    settle();
    chk("t5_state", state_o, 2);
    chk("t5_deadlock", deadlock, 0);
    chk("t5_rdstall", rd_stall_o, T);
    for (int i = 0; i < 10; i++)
      step(NUM_CH'($urandom), NUM_CH'($urandom), '0, '0, 1, 0, 0, 1);
    settle();
    chk("t5_frozen_state", state_o, 2);
    chk("t5_frozen_rdstall", rd_stall_o, T);
    chk("t5_frozen_xfer", xfer_o, 0);

    // stall counter saturation on channel 3 (ch0 writes keep the watchdog quiet)
    idle_step(0, 1, 0, 3);
    idle_step(1, 0, 0, 3);
    repeat (CMAX + 9) step(6'b000001, '0, 6'b001000, '0, 0, 0, 0, 3);
    settle();
    chk("t6_wrstall_sat", wr_stall_o, CMAX);
    idle_step(0, 0, 0, 0);
    settle();
    chk("t6_xfer_sat", xfer_o, CMAX);
    chk("t6_depth_sat", depth_o, DMAX);

    // random traffic, including out-of-range select and quiet bursts
    idle_step(0, 1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      we = NUM_CH'($urandom);
      re = NUM_CH'($urandom);
      wb = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0;
      rb = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0;
      if ((i % 150) >= 100) begin
        wb = NUM_CH'($urandom);
        if ($urandom_range(0, 19) != 0) begin we = '0; re = '0; end
      end
      if ((i % 150) < 40 && $urandom_range(0, 1) == 0) re = '0;
      step(we, re, wb, rb, logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 149) == 0), logic'($urandom_range(0, 249) == 0),
           SEL_W'($urandom_range(0, 7)));
    end

    // asynchronous reset in the middle of a run
    idle_step(0, 1, 0, 0);
    idle_step(1, 0, 0, 0);
    repeat (5) step('1, '0, '1, '1, 0, 0, 0, 0);
    settle();
    chk("t8_pre_xfer", xfer_o, 5);
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    idle_step(0, 0, 0, 0);
    settle();
    chk("t8_after_state", state_o, 0);

    repeat (2) @(posedge clock);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
